// File: rtl/serial_add_ctrl_if.sv
// Handshake and operand/result bundle for the bit-serial add/subtract sequencer.
// The master side issues requests; the slave side is the sequencer itself.
interface serial_add_ctrl_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic             sub;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             ovf;

   modport master (
      output start, sub, a, b, cin,
      input  busy, done, sum, cout, ovf
   );

   modport slave (
      input  start, sub, a, b, cin,
      output busy, done, sum, cout, ovf
   );
endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial WIDTH-bit adder/subtractor: one full-adder cell and a carry FF
// process one bit per clock, LSB first, behind a start/busy/done handshake.
module serial_add_ctrl #(
   parameter int WIDTH = 8
) (
   input logic              clk,
   input logic              rst_n,
   serial_add_ctrl_if.slave bus
);
   localparam int CW = $clog2(WIDTH);
   localparam int PW = WIDTH - 1;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } state_t;

   state_t           state_reg, state_next;
   logic [WIDTH-1:0] a_shift_reg;
   logic [WIDTH-1:0] b_shift_reg;
   logic [PW-1:0]    part_reg;
   logic             carry_reg;
   logic [CW-1:0]    cnt_reg;
   logic [WIDTH-1:0] sum_reg;
   logic             cout_reg;
   logic             ovf_reg;

   logic [WIDTH-1:0] b_load;
   logic             fa_a, fa_b, fa_sum, fa_carry;
   logic             last_bit;
   logic             busy_c, done_c;

   // Subtraction is A + ~B + ~Cin, so B is inverted on the way in.
   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_bload
         assign b_load[gi] = bus.b[gi] ^ bus.sub;
      end
   endgenerate

   assign fa_a     = a_shift_reg[0];
   assign fa_b     = b_shift_reg[0];
   assign fa_sum   = fa_a ^ fa_b ^ carry_reg;
   assign fa_carry = (fa_a & fa_b) | (fa_b & carry_reg) | (fa_a & carry_reg);
   assign last_bit = (cnt_reg == CW'(WIDTH - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = IDLE;
      busy_c     = 1'b0;
      done_c     = 1'b0;
      case (state_reg)
         IDLE: state_next = bus.start ? RUN : IDLE;
         RUN: begin
            busy_c     = 1'b1;
            state_next = last_bit ? DONE : RUN;
         end
         DONE: begin
            done_c     = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_shift_reg <= '0;
         b_shift_reg <= '0;
         part_reg    <= '0;
         carry_reg   <= 1'b0;
         cnt_reg     <= '0;
         sum_reg     <= '0;
         cout_reg    <= 1'b0;
         ovf_reg     <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (bus.start) begin
                  a_shift_reg <= bus.a;
                  b_shift_reg <= b_load;
                  carry_reg   <= bus.cin ^ bus.sub;
                  cnt_reg     <= '0;
               end
            end
            RUN: begin
               a_shift_reg <= a_shift_reg >> 1;
               b_shift_reg <= b_shift_reg >> 1;
               carry_reg   <= fa_carry;
               cnt_reg     <= cnt_reg + CW'(1);
               // Holds bits 0..WIDTH-2 once the final bit arrives.
               part_reg    <= PW'({fa_sum, part_reg} >> 1);
               if (last_bit) begin
                  sum_reg  <= {fa_sum, part_reg};
                  cout_reg <= fa_carry;
                  ovf_reg  <= carry_reg ^ fa_carry;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.busy = busy_c;
   assign bus.done = done_c;
   assign bus.sum  = sum_reg;
   assign bus.cout = cout_reg;
   assign bus.ovf  = ovf_reg;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl: vector table plus hand-built sequences
// for ignored start, mid-run reset and back-to-back operation.
module tb_serial_add_ctrl;
   localparam int WIDTH = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b1;

   serial_add_ctrl_if #(.WIDTH(WIDTH)) bus ();

   serial_add_ctrl #(.WIDTH(WIDTH)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       sub;
      logic [7:0] a;
      logic [7:0] b;
      logic       cin;
      logic [7:0] sum;
      logic       cout;
      logic       ovf;
   } vec_t;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic chk_cleared(input string tag);
      chk({tag, "_busy"}, bus.busy, 0);
      chk({tag, "_done"}, bus.done, 0);
      chk({tag, "_sum"},  bus.sum,  0);
      chk({tag, "_cout"}, bus.cout, 0);
      chk({tag, "_ovf"},  bus.ovf,  0);
   endtask

   // Drives one request, checks timing and result. poke_at/rst_at >= 0 inject
   // a stray start or a reset after that many RUN edges.
   task automatic run_op(input vec_t v, input int poke_at, input int rst_at);
      int n;
      int busy_cnt;
      n        = 0;
      busy_cnt = 0;
      bus.sub   = v.sub;
      bus.a     = v.a;
      bus.b     = v.b;
      bus.cin   = v.cin;
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      bus.a     = ~v.a;
      bus.b     = ~v.b;
      bus.sub   = ~v.sub;
      bus.cin   = ~v.cin;
      while (!bus.done && n < 20) begin
         if (bus.busy) busy_cnt++;
         if (poke_at >= 0 && n == poke_at) begin
            bus.start = 1'b1;
            bus.a     = 8'hC3;
            bus.b     = 8'h77;
            bus.sub   = 1'b1;
         end
         if (poke_at >= 0 && n == poke_at + 1) bus.start = 1'b0;
         if (rst_at >= 0 && n == rst_at) begin
            chk("pre_reset_busy", bus.busy, 1);
            rst_n = 1'b0;
            #1;
            chk_cleared("async_reset");
            @(posedge clk); #1;
            chk_cleared("held_reset");
            rst_n = 1'b1;
            $display("op sub=%0d a=%02h b=%02h cin=%0d aborted by reset after %0d run edges",
                     v.sub, v.a, v.b, v.cin, n);
            return;
         end
         @(posedge clk); #1;
         n++;
      end
      chk("latency", n, WIDTH);
      chk("busy_cycles", busy_cnt, WIDTH);
      chk("busy_with_done", bus.busy, 0);
      chk("sum", bus.sum, v.sum);
      chk("cout", bus.cout, v.cout);
      chk("ovf", bus.ovf, v.ovf);
      $display("op sub=%0d a=%02h b=%02h cin=%0d -> sum=%02h cout=%0d ovf=%0d latency=%0d",
               v.sub, v.a, v.b, v.cin, bus.sum, bus.cout, bus.ovf, n);
      @(posedge clk); #1;
      chk("done_single", bus.done, 0);
      chk("idle_after_done", bus.busy, 0);
      chk("sum_hold", bus.sum, v.sum);
   endtask

   vec_t vecs[10];
   vec_t v;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int cyc;
      int ndone;
      int last;
      logic prev_done;

      vecs[0] = '{1'b0, 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1};
      vecs[1] = '{1'b0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
      vecs[2] = '{1'b0, 8'hFF, 8'h01, 1'b1, 8'h01, 1'b1, 1'b0};
      vecs[3] = '{1'b1, 8'h10, 8'h01, 1'b0, 8'h0F, 1'b1, 1'b0};
      vecs[4] = '{1'b1, 8'h00, 8'h01, 1'b0, 8'hFF, 1'b0, 1'b0};
      vecs[5] = '{1'b0, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
      vecs[6] = '{1'b1, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b1, 1'b1};
      vecs[7] = '{1'b0, 8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0};
      vecs[8] = '{1'b1, 8'h05, 8'h03, 1'b1, 8'h01, 1'b1, 1'b0};
      vecs[9] = '{1'b0, 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};

      bus.start = 1'b0;
      bus.sub   = 1'b0;
      bus.a     = '0;
      bus.b     = '0;
      bus.cin   = 1'b0;

      #3 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk_cleared("reset");
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("idle_no_start", bus.busy, 0);

      for (int i = 0; i < 10; i++) begin
         run_op(vecs[i], -1, -1);
      end

      // Stray start three cycles into RUN must be ignored.
      v = '{1'b0, 8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0};
      run_op(v, 3, -1);

      // Reset four cycles into RUN, then a fresh request on the first edge after release.
      v = '{1'b0, 8'h0F, 8'h0F, 1'b0, 8'h1E, 1'b0, 1'b0};
      run_op(v, -1, 4);
      v = '{1'b0, 8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b0};
      run_op(v, -1, -1);

      // Back-to-back with start held high.
      bus.sub   = 1'b0;
      bus.a     = 8'h11;
      bus.b     = 8'h22;
      bus.cin   = 1'b0;
      bus.start = 1'b1;
      cyc       = 0;
      ndone     = 0;
      last      = -1;
      prev_done = 1'b0;
      repeat (35) begin
         @(posedge clk); #1;
         cyc++;
         if (prev_done) chk("b2b_single_pulse", bus.done, 0);
         if (bus.done) begin
            chk("b2b_sum", bus.sum, 8'h33);
            chk("b2b_busy_with_done", bus.busy, 0);
            if (last >= 0) chk("b2b_period", cyc - last, WIDTH + 2);
            $display("b2b done at cycle %0d sum=%02h", cyc, bus.sum);
            last = cyc;
            ndone++;
         end
         prev_done = bus.done;
      end
      bus.start = 1'b0;
      chk("b2b_count", ndone, 3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
